// File: rtl/exec_pkg.sv
// Shared types and defaults for the exec_sequencer datapath: FSM states, ALU op codes
// and B-operand shift codes.
package exec_pkg;

    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StExec,
        StWb
    } state_e;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpNot = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ShNone = 2'b00,
        ShLsl1 = 2'b01,
        ShLsr1 = 2'b10,
        ShAsr1 = 2'b11
    } shift_e;

endpackage

// File: rtl/alu_shift.sv
// Combinational B-operand shifter, ALU and {Z,N,V} flag generation.
module alu_shift
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    input  shift_e           shift_i,
    output logic [WIDTH-1:0] result_o,
    output logic [2:0]       flags_o
);

    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             ovf;

    always_comb begin
        b_sh = b_i;
        unique case (shift_i)
            ShNone: b_sh = b_i;
            ShLsl1: b_sh = {b_i[WIDTH-2:0], 1'b0};
            ShLsr1: b_sh = {1'b0, b_i[WIDTH-1:1]};
            ShAsr1: b_sh = {b_i[WIDTH-1], b_i[WIDTH-1:1]};
            default: b_sh = b_i;
        endcase
    end

    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (op_i)
            OpAdd: begin
                res = a_i + b_sh;
                // Overflow: operands agree in sign but the result does not.
                ovf = (a_i[WIDTH-1] == b_sh[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OpSub: begin
                res = a_i - b_sh;
                ovf = (a_i[WIDTH-1] != b_sh[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OpAnd: res = a_i & b_sh;
            OpNot: res = ~b_sh;
            default: res = '0;
        endcase
    end

    assign result_o = res;
    assign flags_o  = {(res == '0), res[WIDTH-1], ovf};

endmodule

// File: rtl/exec_sequencer.sv
// Five-state sequencer: reads A and B from an external register file, executes one
// shift+ALU operation and writes the result back, reporting {Z,N,V} status.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [1:0]       shift_i,
    input  logic [2:0]       rn_i,
    input  logic [2:0]       rm_i,
    input  logic [2:0]       rd_i,
    output logic [2:0]       readnum_o,
    input  logic [WIDTH-1:0] rf_data_i,
    output logic             write_o,
    output logic [2:0]       writenum_o,
    output logic [WIDTH-1:0] data_in_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [2:0]       status_o
);

    state_e           state_q, state_d;
    op_e              op_q;
    shift_e           shift_q;
    logic [2:0]       rn_q, rm_q, rd_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [2:0]       status_q;
    logic [WIDTH-1:0] alu_res;
    logic [2:0]       alu_flags;

    alu_shift #(
        .WIDTH(WIDTH)
    ) u_alu_shift (
        .a_i     (a_q),
        .b_i     (b_q),
        .op_i    (op_q),
        .shift_i (shift_q),
        .result_o(alu_res),
        .flags_o (alu_flags)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRdA;
            StRdA:   state_d = StRdB;
            StRdB:   state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            shift_q  <= ShNone;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start_i) begin
                op_q    <= op_e'(op_i);
                shift_q <= shift_e'(shift_i);
                rn_q    <= rn_i;
                rm_q    <= rm_i;
                rd_q    <= rd_i;
            end
            if (state_q == StRdA) a_q <= rf_data_i;
            if (state_q == StRdB) b_q <= rf_data_i;
            if (state_q == StExec) begin
                c_q      <= alu_res;
                status_q <= alu_flags;
            end
        end
    end

    // rm_q is the idle read select so readnum settles to 0 straight out of reset.
    always_comb begin
        readnum_o  = (state_q == StRdA) ? rn_q : rm_q;
        write_o    = (state_q == StWb);
        done_o     = (state_q == StWb);
        busy_o     = (state_q != StIdle);
        writenum_o = rd_q;
        data_in_o  = c_q;
        status_o   = status_q;
    end

endmodule
